// File: rtl/dmem_access_controller.sv
// Data-memory access sequencer for the MEM stage.
// Issues every load/store over a req/ready handshake to a variable-latency
// memory, stalls F/D/E/M and bubbles MEM/WB while an access is outstanding,
// and flags a sticky error if the memory never answers.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   MemReadM, MemWriteM        M-stage load / store indication
//   ALUResultM, WriteDataM     access address and store data
//   mem_req, mem_we            request and direction toward memory
//   mem_addr, mem_wdata        request address and write data
//   mem_ready, mem_rdata       memory completion and read data
//   ReadDataM                  load data toward MEM/WB
//   StallM, BubbleW            pipeline freeze and MEM/WB bubble
//   mem_err                    sticky watchdog error
//   StallCount                 saturating count of stalled cycles
module dmem_access_controller #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  BubbleW,
    output logic                  mem_err,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    localparam int unsigned WAIT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERROR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_cnt_next;
    logic                  err_q;
    logic                  err_next;
    logic                  capture;
    logic                  access;

    assign access    = MemReadM | MemWriteM;
    // Load data passes straight through; it only matters on a completing read.
    assign ReadDataM = mem_rdata;

    // Next-state and output decode.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        err_next      = err_q;
        capture       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        StallM        = 1'b0;
        BubbleW       = 1'b0;
        mem_err       = err_q;

        case (state)
            IDLE: begin
                mem_req   = access;
                mem_we    = MemWriteM;
                mem_addr  = ALUResultM;
                mem_wdata = WriteDataM;
                if (access && !mem_ready) begin
                    StallM        = 1'b1;
                    BubbleW       = 1'b1;
                    capture       = 1'b1;
                    wait_cnt_next = WAIT_W'(1);
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                // Request is replayed from the captured copy so the pipeline
                // inputs may change freely while frozen.
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    state_next = IDLE;
                end else begin
                    StallM  = 1'b1;
                    BubbleW = 1'b1;
                    if (wait_cnt < WAIT_W'(TIMEOUT)) begin
                        wait_cnt_next = wait_cnt + WAIT_W'(1);
                    end else begin
                        err_next   = 1'b1;
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                StallM  = 1'b1;
                BubbleW = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset silences the memory interface in the same cycle, aborting
        // any outstanding request.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            StallM    = 1'b0;
            BubbleW   = 1'b0;
            mem_err   = 1'b0;
        end
    end

    // State, captured request, watchdog and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            StallCount <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            err_q    <= err_next;
            if (capture) begin
                addr_q  <= ALUResultM;
                wdata_q <= WriteDataM;
                we_q    <= MemWriteM;
            end
            if (StallM && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_controller.sv
// Bench for dmem_access_controller: directed scenarios plus a randomized
// run against a transaction-level reference model. A second instance with a
// 4-bit stall counter shares all inputs to exercise counter saturation.
module tb_dmem_access_controller;

    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 4;

    logic          clk;
    logic          rst;
    logic          MemReadM;
    logic          MemWriteM;
    logic [DW-1:0] ALUResultM;
    logic [DW-1:0] WriteDataM;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    logic          mem_req, mem_we, StallM, BubbleW, mem_err;
    logic [DW-1:0] mem_addr, mem_wdata, ReadDataM;
    logic [31:0]   StallCount;

    logic          s_mem_req, s_mem_we, s_StallM, s_BubbleW, s_mem_err;
    logic [DW-1:0] s_mem_addr, s_mem_wdata, s_ReadDataM;
    logic [3:0]    s_StallCount;

    int n_cmp;
    int n_err;

    dmem_access_controller #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
        .StallM(StallM), .BubbleW(BubbleW), .mem_err(mem_err), .StallCount(StallCount)
    );

    dmem_access_controller #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ReadDataM(s_ReadDataM),
        .StallM(s_StallM), .BubbleW(s_BubbleW), .mem_err(s_mem_err), .StallCount(s_StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr, input logic [DW-1:0] a,
                         input logic [DW-1:0] wd, input logic rdy, input logic [DW-1:0] rdat);
        rst = r; MemReadM = rd; MemWriteM = wr; ALUResultM = a;
        WriteDataM = wd; mem_ready = rdy; mem_rdata = rdat;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h123, 32'h456, 1'b0, 32'h0);
        tick();
        // Still in reset with an access pending on the inputs.
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if ({StallM, BubbleW, mem_err} !== 3'b000) begin n_err++; $display("FAIL reset_ctl: got %b want 000", {StallM, BubbleW, mem_err}); end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        n_cmp++; if (StallCount !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", StallCount); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_idle_req: got %b want 0", mem_req); end
        tick();
    endtask

    task automatic test_zero_wait();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_we} !== 2'b10) begin n_err++; $display("FAIL zw_req_we: got %b want 10", {mem_req, mem_we}); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL zw_addr: got %h want 100", mem_addr); end
        n_cmp++; if ({StallM, BubbleW} !== 2'b00) begin n_err++; $display("FAIL zw_stall: got %b want 00", {StallM, BubbleW}); end
        n_cmp++; if (ReadDataM !== 32'hDEADBEEF) begin n_err++; $display("FAIL zw_rdata: got %h want deadbeef", ReadDataM); end
        tick();
        // A second zero-wait load proves the FSM stayed in IDLE.
        drive(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 32'h01234567);
        @(negedge clk);
        n_cmp++; if ({mem_req, StallM} !== 2'b10) begin n_err++; $display("FAIL zw_idle: got %b want 10", {mem_req, StallM}); end
        n_cmp++; if (mem_addr !== 32'h104) begin n_err++; $display("FAIL zw_addr2: got %h want 104", mem_addr); end
        n_cmp++; if (StallCount !== 32'd0) begin n_err++; $display("FAIL zw_cnt: got %0d want 0", StallCount); end
        tick();
    endtask

    task automatic test_wait_load();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({mem_req, StallM, BubbleW} !== 3'b111) begin n_err++; $display("FAIL wl_stall%0d: got %b want 111", c, {mem_req, StallM, BubbleW}); end
            n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL wl_addr%0d: got %h want 100", c, mem_addr); end
            tick();
            ALUResultM = 32'h200;
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++; if ({mem_req, StallM, BubbleW} !== 3'b100) begin n_err++; $display("FAIL wl_rel: got %b want 100", {mem_req, StallM, BubbleW}); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL wl_rel_addr: got %h want 100", mem_addr); end
        n_cmp++; if (ReadDataM !== 32'hCAFEF00D) begin n_err++; $display("FAIL wl_rdata: got %h want cafef00d", ReadDataM); end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        n_cmp++; if (StallCount !== 32'd3) begin n_err++; $display("FAIL wl_cnt: got %0d want 3", StallCount); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h55, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_we, StallM} !== 3'b111) begin n_err++; $display("FAIL bb_st1: got %b want 111", {mem_req, mem_we, StallM}); end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_we, StallM} !== 3'b110) begin n_err++; $display("FAIL bb_st2: got %b want 110", {mem_req, mem_we, StallM}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== {32'h10, 32'h55}) begin n_err++; $display("FAIL bb_st2_payload: got %h/%h want 10/55", mem_addr, mem_wdata); end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'h77);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_we, StallM} !== 3'b100) begin n_err++; $display("FAIL bb_ld: got %b want 100", {mem_req, mem_we, StallM}); end
        n_cmp++; if (mem_addr !== 32'h14) begin n_err++; $display("FAIL bb_ld_addr: got %h want 14", mem_addr); end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        n_cmp++; if (StallCount !== 32'd1) begin n_err++; $display("FAIL bb_cnt: got %0d want 1", StallCount); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++; if (StallM !== 1'b1) begin n_err++; $display("FAIL to_first: got %b want 1", StallM); end
        tick();
        for (int c = 0; c < int'(TO); c++) begin
            @(negedge clk);
            n_cmp++; if ({mem_req, StallM, mem_err} !== 3'b110) begin n_err++; $display("FAIL to_wait%0d: got %b want 110", c, {mem_req, StallM, mem_err}); end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            mem_ready = (c == 7);
            @(negedge clk);
            n_cmp++; if ({mem_req, StallM, BubbleW, mem_err} !== 4'b0111) begin n_err++; $display("FAIL to_err%0d: got %b want 0111", c, {mem_req, StallM, BubbleW, mem_err}); end
            if (c == 0) begin
                n_cmp++; if (StallCount !== 32'd5) begin n_err++; $display("FAIL to_cnt0: got %0d want 5", StallCount); end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (StallCount !== 32'd25) begin n_err++; $display("FAIL to_cnt: got %0d want 25", StallCount); end
        n_cmp++; if (s_StallCount !== 4'hF) begin n_err++; $display("FAIL sat_cnt: got %h want f", s_StallCount); end
        n_cmp++; if ({s_StallM, s_mem_err} !== 2'b11) begin n_err++; $display("FAIL sat_err: got %b want 11", {s_StallM, s_mem_err}); end
        tick();
        @(negedge clk);
        n_cmp++; if (s_StallCount !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %h want f", s_StallCount); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({mem_req, StallM, BubbleW, mem_err} !== 4'b0000) begin n_err++; $display("FAIL to_rst: got %b want 0000", {mem_req, StallM, BubbleW, mem_err}); end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        n_cmp++; if ({StallCount, s_StallCount} !== 36'd0) begin n_err++; $display("FAIL to_rst_cnt: got %0d/%0d want 0/0", StallCount, s_StallCount); end
        n_cmp++; if ({StallM, mem_err} !== 2'b00) begin n_err++; $display("FAIL to_rst_state: got %b want 00", {StallM, mem_err}); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mem_req, StallM} !== 2'b00) begin n_err++; $display("FAIL rmw_abort: got %b want 00", {mem_req, StallM}); end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'h99);
        @(negedge clk);
        n_cmp++; if ({mem_req, StallM} !== 2'b10) begin n_err++; $display("FAIL rmw_new: got %b want 10", {mem_req, StallM}); end
        n_cmp++; if (mem_addr !== 32'h44) begin n_err++; $display("FAIL rmw_addr: got %h want 44", mem_addr); end
        tick();
    endtask

    task automatic test_both_set();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 32'h80, 32'hAA, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin n_err++; $display("FAIL both_we: got %b want 11", {mem_req, mem_we}); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        n_cmp++; if ({mem_we, StallM} !== 2'b10) begin n_err++; $display("FAIL both_rel: got %b want 10", {mem_we, StallM}); end
        tick();
    endtask

    // Transaction-level model: an access either completes, keeps waiting, or
    // times out after TO unanswered wait cycles, after which everything halts.
    task automatic test_random();
        bit            m_pend, m_err, m_we;
        int            m_waited;
        longint        m_cnt;
        logic [DW-1:0] m_addr, m_wdata;
        logic          e_req, e_we, e_stall, e_err;
        logic [DW-1:0] e_addr, e_wdata;
        logic [3:0]    e_scnt;
        do_reset();
        m_pend = 0; m_err = 0; m_we = 0; m_waited = 0; m_cnt = 0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
            e_req = 0; e_we = 0; e_stall = 0; e_err = 0; e_addr = '0; e_wdata = '0;
            if (rst) begin
                e_err = 0;
            end else if (m_err) begin
                e_stall = 1; e_err = 1;
            end else if (m_pend) begin
                e_req = 1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
                e_stall = !mem_ready;
            end else begin
                e_req = MemReadM | MemWriteM; e_we = MemWriteM;
                e_addr = ALUResultM; e_wdata = WriteDataM;
                e_stall = e_req && !mem_ready;
            end
            e_scnt = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
            @(negedge clk);
            n_cmp++; if (StallCount !== 32'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, StallCount, m_cnt); end
            n_cmp++; if (s_StallCount !== e_scnt) begin n_err++; $display("FAIL rnd_scnt[%0d]: got %0d want %0d", i, s_StallCount, e_scnt); end
            n_cmp++; if (mem_req !== e_req) begin n_err++; $display("FAIL rnd_req[%0d]: got %b want %b", i, mem_req, e_req); end
            n_cmp++; if ({StallM, BubbleW} !== {e_stall, e_stall}) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b%b", i, {StallM, BubbleW}, e_stall, e_stall); end
            n_cmp++; if (mem_err !== e_err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", i, mem_err, e_err); end
            n_cmp++; if (ReadDataM !== mem_rdata) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, ReadDataM, mem_rdata); end
            if (e_req) begin
                n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wdata}) begin n_err++; $display("FAIL rnd_payload[%0d]: got %b/%h/%h want %b/%h/%h", i, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata); end
            end
            if (rst) begin
                m_pend = 0; m_err = 0; m_waited = 0; m_cnt = 0;
            end else begin
                if (e_stall) m_cnt++;
                if (!m_err && m_pend) begin
                    if (mem_ready) m_pend = 0;
                    else begin
                        m_waited++;
                        if (m_waited == int'(TO)) begin m_err = 1; m_pend = 0; end
                    end
                end else if (!m_err && e_stall) begin
                    m_pend = 1; m_waited = 0; m_we = MemWriteM; m_addr = ALUResultM; m_wdata = WriteDataM;
                end
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        test_reset();
        test_zero_wait();
        test_wait_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_both_set();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
